// File: rtl/pf_iod_clk_train_pkg.sv
// Shared types and constants for the IOD clock-training controller.
// Sweep, timing and pattern constants live here so the controller and window tracker agree.
package pf_iod_clk_train_pkg;

    localparam int NUM_TAPS      = 32;
    localparam int SETTLE_CYCLES = 16;
    localparam int SAMPLE_CYCLES = 64;
    localparam int MIN_WINDOW    = 4;
    localparam int ACK_TIMEOUT   = 255;

    localparam int TAP_W    = $clog2(NUM_TAPS);
    localparam int SETTLE_W = $clog2(SETTLE_CYCLES);
    localparam int SAMPLE_W = $clog2(SAMPLE_CYCLES);
    localparam int TMO_W    = $clog2(ACK_TIMEOUT + 1);

    localparam logic [2:0] EYE_WIDTH   = 3'b001;
    localparam logic [7:0] TRAIN_PAT_A = 8'h55;
    localparam logic [7:0] TRAIN_PAT_B = 8'hAA;

    typedef enum logic [3:0] {
        S_IDLE,
        S_STEP,
        S_SETTLE,
        S_CLEAR,
        S_SAMPLE,
        S_EVAL,
        S_CENTER,
        S_DONE,
        S_ERR
    } train_state_t;

endpackage

// File: rtl/pf_iod_clk_train_window.sv
// Tracks contiguous pass runs across the tap sweep and keeps the earliest longest one.
// The centre output is best_start + best_len/2, truncated to the tap width.
module pf_iod_clk_train_window
    import pf_iod_clk_train_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic             i_valid,
    input  logic             i_pass,
    input  logic             i_last,
    output logic [TAP_W-1:0] o_best_start,
    output logic [TAP_W:0]   o_best_len,
    output logic [TAP_W-1:0] o_centre
);

    logic [TAP_W-1:0] r_idx;
    logic [TAP_W-1:0] r_run_start;
    logic [TAP_W:0]   r_run_len;
    logic [TAP_W-1:0] r_best_start;
    logic [TAP_W:0]   r_best_len;

    logic [TAP_W:0]   w_ext_len;
    logic [TAP_W-1:0] w_ext_start;
    logic [TAP_W:0]   w_cand_len;
    logic [TAP_W-1:0] w_cand_start;
    logic             w_close;

    assign w_ext_len    = r_run_len + 1'b1;
    assign w_ext_start  = (r_run_len == '0) ? r_idx : r_run_start;
    assign w_cand_len   = i_pass ? w_ext_len   : r_run_len;
    assign w_cand_start = i_pass ? w_ext_start : r_run_start;
    // A fail ends the run; the final tap also ends it so an open window is not lost.
    assign w_close      = !i_pass || i_last;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_idx        <= '0;
            r_run_start  <= '0;
            r_run_len    <= '0;
            r_best_start <= '0;
            r_best_len   <= '0;
        end else if (i_clr) begin
            r_idx        <= '0;
            r_run_start  <= '0;
            r_run_len    <= '0;
            r_best_start <= '0;
            r_best_len   <= '0;
        end else if (i_valid) begin
            r_idx <= r_idx + 1'b1;
            if (i_pass && !i_last) begin
                r_run_start <= w_ext_start;
                r_run_len   <= w_ext_len;
            end else begin
                r_run_len <= '0;
            end
            // Strictly longer only, so the earliest of equal runs is kept.
            if (w_close && (w_cand_len > r_best_len)) begin
                r_best_start <= w_cand_start;
                r_best_len   <= w_cand_len;
            end
        end
    end

    assign o_best_start = r_best_start;
    assign o_best_len   = r_best_len;
    assign o_centre     = r_best_start + TAP_W'(r_best_len >> 1);

endmodule

// File: rtl/pf_iod_clk_train_ctrl.sv
// IOD clock-training controller: sweeps phase taps, scores each with the eye monitor, centres on the widest window.
// Optional build macro CLK_TRAIN_PATTERN_CHECK_EN also fails taps whose RX_DATA is not the 55/AA training pattern.
module pf_iod_clk_train_ctrl
    import pf_iod_clk_train_pkg::*;
(
    input  logic             i_fab_clk,
    input  logic             i_arst_n,
    input  logic             i_train_start,
    input  logic             i_eye_monitor_early,
    input  logic             i_eye_monitor_late,
    input  logic [7:0]       i_rx_data,
    output logic             o_eye_monitor_clear_flags,
    output logic [2:0]       o_eye_monitor_lane_width,
    output logic             o_phase_step,
    output logic             o_phase_dir,
    input  logic             i_phase_ack,
    output logic             o_busy,
    output logic             o_train_done,
    output logic             o_train_err,
    output logic [TAP_W-1:0] o_tap_result,
    output logic [TAP_W:0]   o_window_len
);

    train_state_t     r_state;
    logic [TAP_W-1:0] r_tap;
    logic [SETTLE_W-1:0] r_set_cnt;
    logic [SAMPLE_W-1:0] r_smp_cnt;
    logic [TMO_W-1:0] r_tmo_cnt;
    logic [TAP_W-1:0] r_moves;
    logic             r_center_load;
    logic             r_early;
    logic             r_late;
    logic             r_fail;
    logic             r_clear;
    logic             r_step;
    logic             r_dir;
    logic             r_busy;
    logic             r_done;
    logic             r_err;
    logic [TAP_W-1:0] r_tap_result;
    logic [TAP_W:0]   r_window_len;

    logic             w_pat_bad;
    logic             w_flag_hit;
    logic             w_win_clr;
    logic             w_win_valid;
    logic             w_win_last;
    logic [TAP_W-1:0] w_best_start_unused;
    logic [TAP_W:0]   w_best_len;
    logic [TAP_W-1:0] w_centre;

`ifdef CLK_TRAIN_PATTERN_CHECK_EN
    logic [7:0] r_rx;

    always_ff @(posedge i_fab_clk or negedge i_arst_n) begin
        if (!i_arst_n) r_rx <= '0;
        else           r_rx <= i_rx_data;
    end

    // The first two sample cycles may still carry data from before the flag clear.
    assign w_pat_bad = (r_smp_cnt >= SAMPLE_W'(2)) &&
                       (r_rx != TRAIN_PAT_A) && (r_rx != TRAIN_PAT_B);
`else
    logic w_rx_unused;
    assign w_rx_unused = ^i_rx_data;
    assign w_pat_bad   = 1'b0;
`endif

    assign w_flag_hit  = r_early | r_late | w_pat_bad;
    assign w_win_clr   = ((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR)) && i_train_start;
    assign w_win_valid = (r_state == S_EVAL);
    assign w_win_last  = (r_tap == TAP_W'(NUM_TAPS - 1));

    pf_iod_clk_train_window u_window (
        .i_clk        (i_fab_clk),
        .i_rst_n      (i_arst_n),
        .i_clr        (w_win_clr),
        .i_valid      (w_win_valid),
        .i_pass       (!r_fail),
        .i_last       (w_win_last),
        .o_best_start (w_best_start_unused),
        .o_best_len   (w_best_len),
        .o_centre     (w_centre)
    );

    always_ff @(posedge i_fab_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            r_state       <= S_IDLE;
            r_tap         <= '0;
            r_set_cnt     <= '0;
            r_smp_cnt     <= '0;
            r_tmo_cnt     <= '0;
            r_moves       <= '0;
            r_center_load <= 1'b0;
            r_early       <= 1'b0;
            r_late        <= 1'b0;
            r_fail        <= 1'b0;
            r_clear       <= 1'b0;
            r_step        <= 1'b0;
            r_dir         <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
            r_tap_result  <= '0;
            r_window_len  <= '0;
        end else begin
            r_early <= i_eye_monitor_early;
            r_late  <= i_eye_monitor_late;
            case (r_state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (i_train_start) begin
                        r_done       <= 1'b0;
                        r_err        <= 1'b0;
                        r_tap_result <= '0;
                        r_window_len <= '0;
                        r_tap        <= '0;
                        r_set_cnt    <= '0;
                        r_busy       <= 1'b1;
                        r_state      <= S_SETTLE;
                    end
                end
                S_STEP: begin
                    if (i_phase_ack) begin
                        r_step    <= 1'b0;
                        r_set_cnt <= '0;
                        r_state   <= r_dir ? S_SETTLE : S_CENTER;
                    end else if (r_tmo_cnt == TMO_W'(ACK_TIMEOUT - 1)) begin
                        r_step       <= 1'b0;
                        r_busy       <= 1'b0;
                        r_err        <= 1'b1;
                        r_tap_result <= '0;
                        r_window_len <= w_best_len;
                        r_state      <= S_ERR;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    end
                end
                S_SETTLE: begin
                    if (r_set_cnt == SETTLE_W'(SETTLE_CYCLES - 1)) begin
                        r_clear   <= 1'b1;
                        r_smp_cnt <= '0;
                        r_state   <= S_CLEAR;
                    end else begin
                        r_set_cnt <= r_set_cnt + 1'b1;
                    end
                end
                S_CLEAR: begin
                    // The sample counter doubles as the two-cycle clear timer.
                    if (r_smp_cnt == '0) begin
                        r_smp_cnt <= SAMPLE_W'(1);
                    end else begin
                        r_clear   <= 1'b0;
                        r_smp_cnt <= '0;
                        r_fail    <= 1'b0;
                        r_state   <= S_SAMPLE;
                    end
                end
                S_SAMPLE: begin
                    r_fail <= r_fail | w_flag_hit;
                    if (r_smp_cnt == SAMPLE_W'(SAMPLE_CYCLES - 1)) r_state   <= S_EVAL;
                    else                                           r_smp_cnt <= r_smp_cnt + 1'b1;
                end
                S_EVAL: begin
                    if (w_win_last) begin
                        r_center_load <= 1'b1;
                        r_state       <= S_CENTER;
                    end else begin
                        r_tap     <= r_tap + 1'b1;
                        r_dir     <= 1'b1;
                        r_step    <= 1'b1;
                        r_tmo_cnt <= '0;
                        r_state   <= S_STEP;
                    end
                end
                S_CENTER: begin
                    // First visit waits one cycle for the tracker to absorb the last tap.
                    if (r_center_load) begin
                        r_center_load <= 1'b0;
                        r_window_len  <= w_best_len;
                        if (w_best_len < (TAP_W + 1)'(MIN_WINDOW)) begin
                            r_tap_result <= '0;
                            r_busy       <= 1'b0;
                            r_err        <= 1'b1;
                            r_state      <= S_ERR;
                        end else begin
                            r_tap_result <= w_centre;
                            r_moves      <= TAP_W'(NUM_TAPS - 1) - w_centre;
                        end
                    end else if (r_moves == '0) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_moves   <= r_moves - 1'b1;
                        r_dir     <= 1'b0;
                        r_step    <= 1'b1;
                        r_tmo_cnt <= '0;
                        r_state   <= S_STEP;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_eye_monitor_clear_flags = r_clear;
    assign o_eye_monitor_lane_width  = EYE_WIDTH;
    assign o_phase_step              = r_step;
    assign o_phase_dir               = r_dir;
    assign o_busy                    = r_busy;
    assign o_train_done              = r_done;
    assign o_train_err               = r_err;
    assign o_tap_result              = r_tap_result;
    assign o_window_len              = r_window_len;

endmodule

// File: tb/tb_pf_iod_clk_train_ctrl.sv
// Bench for pf_iod_clk_train_ctrl: emulates the IOD eye monitor and CCC phase port, checks against a window model.
// Honours CLK_TRAIN_PATTERN_CHECK_EN the same way the design does.
module tb_pf_iod_clk_train_ctrl;
    import pf_iod_clk_train_pkg::*;

`ifdef CLK_TRAIN_PATTERN_CHECK_EN
    localparam bit PAT_EN = 1'b1;
`else
    localparam bit PAT_EN = 1'b0;
`endif

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             early = 1'b0;
    logic             late  = 1'b0;
    logic             ack   = 1'b0;
    logic [7:0]       rx    = 8'h55;
    logic             o_clear;
    logic [2:0]       o_width;
    logic             o_phase_step;
    logic             o_phase_dir;
    logic             o_busy;
    logic             o_train_done;
    logic             o_train_err;
    logic [TAP_W-1:0] o_tap_result;
    logic [TAP_W:0]   o_window_len;

    pf_iod_clk_train_ctrl dut (
        .i_fab_clk                 (clk),
        .i_arst_n                  (rst_n),
        .i_train_start             (start),
        .i_eye_monitor_early       (early),
        .i_eye_monitor_late        (late),
        .i_rx_data                 (rx),
        .o_eye_monitor_clear_flags (o_clear),
        .o_eye_monitor_lane_width  (o_width),
        .o_phase_step              (o_phase_step),
        .o_phase_dir               (o_phase_dir),
        .i_phase_ack               (ack),
        .o_busy                    (o_busy),
        .o_train_done              (o_train_done),
        .o_train_err               (o_train_err),
        .o_tap_result              (o_tap_result),
        .o_window_len              (o_window_len)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Channel description per tap: sticky flag sources and the data the lane delivers.
    logic       bad_e  [NUM_TAPS];
    logic       bad_l  [NUM_TAPS];
    logic [7:0] rx_tab [NUM_TAPS];
    int         withhold_tap = -1;

    int   tap_tb = 0, n_up = 0, n_dn = 0, n_clr = 0, dly = 0, ti = 0;
    logic ack_dir = 1'b0;

    // IOD + CCC emulation, driven on the falling edge.
    always @(negedge clk) begin
        if (start && !o_busy) begin
            tap_tb = 0; n_up = 0; n_dn = 0; n_clr = 0;
        end
        if (!rst_n) begin
            ack = 1'b0;
        end else if (ack) begin
            ack = 1'b0;
            if (ack_dir) begin tap_tb++; n_up++; end
            else         begin tap_tb--; n_dn++; end
        end else if (o_phase_step && !(o_phase_dir && (tap_tb + 1 == withhold_tap))) begin
            if (dly == 0) begin
                ack     = 1'b1;
                ack_dir = o_phase_dir;
                dly     = int'($urandom_range(0, 3));
            end else begin
                dly--;
            end
        end
        ti = ((tap_tb % NUM_TAPS) + NUM_TAPS) % NUM_TAPS;
        if (o_clear) begin
            n_clr++;
            early = 1'b0;
            late  = 1'b0;
        end else begin
            if (bad_e[ti]) early = 1'b1;
            if (bad_l[ti]) late  = 1'b1;
        end
        rx = rx_tab[ti];
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic bit tap_pass(input int t);
        bit pat_ok;
        pat_ok = (rx_tab[t] == 8'h55) || (rx_tab[t] == 8'hAA);
        return !bad_e[t] && !bad_l[t] && (!PAT_EN || pat_ok);
    endfunction

    // For every run start, measure its length; strictly-longer keeps the earliest.
    task automatic model(input int ntaps, output int bstart, output int blen);
        int len;
        bstart = 0;
        blen   = 0;
        for (int s = 0; s < ntaps; s++) begin
            if (tap_pass(s) && (s == 0 || !tap_pass(s - 1))) begin
                len = 0;
                while (s + len < ntaps && tap_pass(s + len)) len++;
                if (len > blen) begin bstart = s; blen = len; end
            end
        end
    endtask

    task automatic set_taps(input int lo0, input int hi0, input int lo1, input int hi1);
        bit p;
        for (int t = 0; t < NUM_TAPS; t++) begin
            p         = (t >= lo0 && t <= hi0) || (t >= lo1 && t <= hi1);
            bad_e[t]  = !p && (t % 2 == 0);
            bad_l[t]  = !p && (t % 2 == 1);
            rx_tab[t] = (t % 2 == 0) ? 8'h55 : 8'hAA;
        end
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic do_run(input string name, input int lit_tap, input bit mid_start);
        int bs, bl, et, ok;
        bit good;
        model(NUM_TAPS, bs, bl);
        good = (bl >= MIN_WINDOW);
        et   = good ? (bs + bl / 2) % NUM_TAPS : 0;
        pulse_start();
        check({name, ":busy_after_start"}, o_busy, 1);
        ok = 0;
        for (int i = 0; i < 8000; i++) begin
            if (o_train_done || o_train_err) begin ok = 1; break; end
            start = mid_start && (i == 500);
            @(posedge clk); #1;
        end
        start = 1'b0;
        check({name, ":finished"},  ok, 1);
        check({name, ":done"},      o_train_done, good);
        check({name, ":err"},       o_train_err, !good);
        check({name, ":tap"},       o_tap_result, et);
        check({name, ":win_len"},   o_window_len, bl);
        check({name, ":up_steps"},  n_up, NUM_TAPS - 1);
        check({name, ":dn_steps"},  n_dn, good ? NUM_TAPS - 1 - et : 0);
        check({name, ":clr_cyc"},   n_clr, 2 * NUM_TAPS);
        check({name, ":busy_end"},  o_busy, 0);
        check({name, ":step_end"},  o_phase_step, 0);
        if (lit_tap >= 0) check({name, ":tap_literal"}, o_tap_result, lit_tap);
        $display("[TB] run %s: tap=%0d len=%0d done=%0d err=%0d up=%0d dn=%0d",
                 name, o_tap_result, o_window_len, o_train_done, o_train_err, n_up, n_dn);
    endtask

    task automatic reset_pulse(input string name);
        rst_n = 1'b0;
        #1;
        check({name, ":step"},  o_phase_step, 0);
        check({name, ":busy"},  o_busy, 0);
        check({name, ":clear"}, o_clear, 0);
        check({name, ":err"},   o_train_err, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        $display("[TB] %s applied", name);
    endtask

    initial begin
        int bs, bl, ok, t0;
        set_taps(0, NUM_TAPS - 1, -1, -1);
        #12;
        check("rst:step",    o_phase_step, 0);
        check("rst:dir",     o_phase_dir, 0);
        check("rst:clear",   o_clear, 0);
        check("rst:busy",    o_busy, 0);
        check("rst:done",    o_train_done, 0);
        check("rst:err",     o_train_err, 0);
        check("rst:tap",     o_tap_result, 0);
        check("rst:win_len", o_window_len, 0);
        check("rst:width",   o_width, 3'b001);
        @(posedge clk); #1 rst_n = 1'b1;

        set_taps(10, 17, -1, -1);
        do_run("win_10_17", 14, 1'b0);

        set_taps(2, 5, 20, 23);
        do_run("equal_runs", 4, 1'b1);

        set_taps(-1, -1, -1, -1);
        for (int t = 0; t < NUM_TAPS; t++) begin bad_e[t] = 1'b1; bad_l[t] = 1'b0; end
        do_run("all_early", 0, 1'b0);

        for (int r = 0; r < 3; r++) begin
            for (int t = 0; t < NUM_TAPS; t++) begin
                int x;
                x         = int'($urandom_range(0, 9));
                bad_e[t]  = (x == 0);
                bad_l[t]  = (x == 1);
                rx_tab[t] = ($urandom_range(0, 1) == 1) ? 8'h55 : 8'hAA;
            end
            do_run($sformatf("random%0d", r), -1, 1'b0);
        end

        set_taps(0, 4, -1, -1);
        withhold_tap = 7;
        pulse_start();
        ok = 0;
        for (int i = 0; i < 2000; i++) begin
            if (o_phase_step && tap_tb == 6) begin ok = 1; break; end
            @(posedge clk); #1;
        end
        check("tmo:step_to_7", ok, 1);
        t0 = cyc;
        ok = 0;
        for (int i = 0; i < 600; i++) begin
            if (o_train_err) begin ok = 1; break; end
            @(posedge clk); #1;
        end
        model(7, bs, bl);
        check("tmo:err",     ok, 1);
        check("tmo:cycles",  cyc - t0, ACK_TIMEOUT);
        check("tmo:step",    o_phase_step, 0);
        check("tmo:busy",    o_busy, 0);
        check("tmo:done",    o_train_done, 0);
        check("tmo:tap",     o_tap_result, 0);
        check("tmo:win_len", o_window_len, bl);
        $display("[TB] run ack_timeout: err=%0d cycles=%0d len=%0d", o_train_err, cyc - t0, o_window_len);

        set_taps(10, 17, -1, -1);
        withhold_tap = 3;
        pulse_start();
        ok = 0;
        for (int i = 0; i < 2000; i++) begin
            if (o_phase_step && tap_tb == 2) begin ok = 1; break; end
            @(posedge clk); #1;
        end
        check("rst_step:seen", ok, 1);
        repeat (3) begin @(posedge clk); #1; end
        reset_pulse("rst_in_step");
        withhold_tap = -1;

        pulse_start();
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            if (o_clear) begin ok = 1; break; end
            @(posedge clk); #1;
        end
        check("rst_sample:clear_seen", ok, 1);
        repeat (10) begin @(posedge clk); #1; end
        reset_pulse("rst_in_sample");
        do_run("after_reset", 14, 1'b0);

        for (int t = 0; t < NUM_TAPS; t++) begin
            bad_e[t]  = 1'b0;
            bad_l[t]  = 1'b0;
            rx_tab[t] = (t < 16) ? 8'h33 : 8'h55;
        end
        if (PAT_EN) do_run("pattern_check", 24, 1'b0);
        else        do_run("rx_ignored", 16, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
